// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 decryption, one round per clock.
// A cache miss first runs the forward key schedule from K1 up to K32. The core then
// undoes the 31 rounds while it walks the schedule back down to K1. A one-entry
// cache holds the last K1/K32 pair, so a block that reuses the previous key skips
// the forward expansion.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   idat   in   64-bit ciphertext, captured on the accepted start edge
//   key    in   80-bit user key K1, captured on the accepted start edge
//   odat   out  64-bit plaintext, registered, held until the next done
//   done   out  one-cycle pulse, odat valid from this cycle on
//   busy   out  high while key expansion or decryption rounds are running
module present_decrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] idat,
  input  logic [79:0] key,
  output logic [63:0] odat,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StKeyExp, StDec, StFin} state_e;

  state_e      state_q;
  logic [63:0] dreg_q;
  logic [79:0] kreg_q;
  logic [4:0]  rnd_q;
  logic [79:0] cache_k1_q;
  logic [79:0] cache_k32_q;
  logic        cache_vld_q;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Forward schedule step: rotate left 61, S-box top nibble, mix in round counter.
  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of key_fwd for the same round counter.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  logic [63:0] xk;
  logic [63:0] perm;
  logic [63:0] round_out;
  logic [79:0] kfwd;
  logic [79:0] kinv;

  assign xk   = dreg_q ^ kreg_q[79:16];
  assign kfwd = key_fwd(kreg_q, rnd_q);
  assign kinv = key_inv(kreg_q, rnd_q);

  // The forward layer moves bit 4j+b to 16b+j, so the inverse pulls it back.
  for (genvar j = 0; j < 16; j++) begin : g_inv_perm
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign perm[4*j+b] = xk[16*b+j];
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_inv_sbox
    assign round_out[4*n +: 4] = inv_sbox(perm[4*n +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dreg_q      <= '0;
      kreg_q      <= '0;
      rnd_q       <= '0;
      cache_k1_q  <= '0;
      cache_k32_q <= '0;
      cache_vld_q <= 1'b0;
      odat        <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dreg_q <= idat;
            if (cache_vld_q && (key == cache_k1_q)) begin
              kreg_q  <= cache_k32_q;
              rnd_q   <= 5'd31;
              state_q <= StDec;
            end else begin
              // Invalidate up front so an aborted expansion never leaves a stale K32.
              kreg_q      <= key;
              cache_k1_q  <= key;
              cache_vld_q <= 1'b0;
              rnd_q       <= 5'd1;
              state_q     <= StKeyExp;
            end
          end
        end
        StKeyExp: begin
          busy   <= 1'b1;
          kreg_q <= kfwd;
          if (rnd_q == 5'd31) begin
            cache_k32_q <= kfwd;
            cache_vld_q <= 1'b1;
            state_q     <= StDec;
          end else begin
            rnd_q <= rnd_q + 5'd1;
          end
        end
        StDec: begin
          busy   <= 1'b1;
          dreg_q <= round_out;
          kreg_q <= kinv;
          if (rnd_q == 5'd1) begin
            state_q <= StFin;
          end else begin
            rnd_q <= rnd_q - 5'd1;
          end
        end
        StFin: begin
          // kreg_q is back at K1 here, the whitening key of the first round.
          odat    <= dreg_q ^ kreg_q[79:16];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/present_decrypt.md
# present_decrypt

Iterative PRESENT-80 decryption core, the inverse of the team's PRESENT encryption core; it turns a 64-bit ciphertext and the 80-bit user key into plaintext, one round per clock. It first runs the forward key schedule to reach round key K32, then walks the schedule backwards while undoing the rounds. A one-entry key cache skips that forward key expansion when consecutive blocks share the same key. It sits beside the encryption core in the FPGA test setup and is used to check captured ciphertexts.

## Interface

- Parameters: none (PRESENT-80, 31 rounds, fixed).
- clk  in  1  rising-edge clock, the only clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- idat  in  64  ciphertext, captured on the accepted start edge
- key  in  80  user key K1 (same key the encryptor loads), captured on the accepted start edge
- odat  out  64  plaintext, registered; holds its value until the next done
- done  out  1  one-cycle pulse; odat is valid from this cycle onward
- busy  out  1  high from the cycle after start is accepted until the cycle done rises

## Operation

- Registers: dreg[63:0] (state), kreg[79:0] (round key), rnd[4:0], FSM state, cache_k1[79:0], cache_k32[79:0], cache_vld.
- Forward key update f(k,r): rotate left 61, S-box on bits [79:76], bits [19:15] ^= r.
- Inverse key update g(k,r): bits [19:15] ^= r, inverse S-box on bits [79:76], rotate right 61. g(f(k,r),r)=k.
- One decrypt round: dreg <= invS(invP(dreg ^ kreg)).
  - invP: inverse of P(i)=16·i mod 63, with bit 63 fixed.
  - invS: 16 inverse-S-box nibbles.
- States:
  - IDLE
    - On start: dreg<=idat.
    - Cache hit (cache_vld && key==cache_k1): kreg<=cache_k32, rnd<=31, go to DEC.
    - Cache miss: kreg<=key, cache_k1<=key, cache_vld<=0, rnd<=1, go to KEYEXP.
  - KEYEXP: each cycle kreg<=f(kreg,rnd), rnd<=rnd+1.
    - On the cycle rnd==31: write f(kreg,31) to both kreg and cache_k32, set cache_vld<=1, rnd<=31, go to DEC.
  - DEC: each cycle apply one decrypt round, kreg<=g(kreg,rnd), rnd<=rnd-1.
    - On the cycle rnd==1: go to FIN. At that point kreg==K1.
  - FIN: odat<=dreg^kreg, done<=1, go to IDLE.
- Key cache behaviour:
  - A miss always overwrites the cache.
  - cache_vld is cleared at the start of a miss, so an aborted expansion never leaves a stale K32.
- start while busy is ignored; there is no queueing.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - odat=0, done=0, busy=0, cache_vld=0.
  - An in-flight block is discarded with no done pulse.

## Timing

- Counting the start-sampling edge as E0:
  - Cache miss: KEYEXP on E1–E31, DEC on E32–E62, FIN on E63. done is high the cycle after E63, for a latency of 63 cycles.
  - Cache hit: DEC on E1–E31, FIN on E32, for a latency of 32 cycles.
- done lasts exactly one cycle. busy is low in that same cycle.
- start asserted during the done cycle is accepted, because the FSM is in IDLE. Back-to-back throughput on cache hits is therefore one block per 33 cycles.
- idat and key may change after E0; later changes do not affect the block in flight.
- rnd never wraps: its range is 1..31 in KEYEXP and 31..1 in DEC.

## Test plan

- Reset, then key=0, idat=5579C1387B228445 -> 63 cycles later done=1, odat=0000000000000000; busy high exactly 62 cycles.
- Same key=0 again, idat=A112FFC72F68417B -> cache hit, done after 32 cycles, odat=FFFFFFFFFFFFFFFF.
- key=FFFF_FFFFFFFFFFFFFFFF, idat=E72C46C0F5945049 -> miss, 63 cycles, odat=0000000000000000. Then idat=3333DCD3213210D2 with the same key -> hit, 32 cycles, odat=FFFFFFFFFFFFFFFF.
- Pulse start repeatedly while busy -> ignored: a single done, and the result is unchanged.
- Assert rst_n=0 during KEYEXP (cycle 10), release, then restart with the same key -> miss path (63 cycles), because the cache was invalidated, and the plaintext is correct. Also reset during DEC -> no done, odat=0.
- Random loopback: encryption core output fed back with the same key over 1000 random pairs -> plaintext recovered every time; the cache-hit and miss paths give identical results.
